// File: rtl/pid_pwm_out.sv
// Purpose: saturate a signed Q-format PID output, scale it to a PWM duty count and drive a fixed-period PWM pin plus a direction pin.
// Latency: pid_valid at cycle N -> pending duty at N+2 -> active at the next period wrap (next edge while disabled).
// Backpressure: none; a sample is accepted every cycle and the newest one overwrites the pending duty.
//
// Ports:
//   clk, rstb      clock, asynchronous active-low reset
//   enable         runs the period counter; low holds the counter at 0 and pwm low
//   pid_out        signed controller output, 2^Q_BITS = 100 % duty
//   pid_valid      single-cycle strobe qualifying pid_out
//   pwm, dir       registered PWM pin and direction (1 = negative command)
//   duty           duty count currently in force
//   sat_flag       last captured sample was clamped to full scale
//   period_start   one-cycle pulse in the first cycle of each period
//   update_ack     one-cycle pulse after the pending duty loads into the active register
module pid_pwm_out #(
    parameter int D_WIDTH   = 16,
    parameter int Q_BITS    = 13,
    parameter int CNT_WIDTH = 10,
    parameter int PERIOD    = 1000,
    parameter int MIN_PULSE = 2
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 enable,
    input  logic [D_WIDTH-1:0]   pid_out,
    input  logic                 pid_valid,
    output logic                 pwm,
    output logic                 dir,
    output logic [CNT_WIDTH-1:0] duty,
    output logic                 sat_flag,
    output logic                 period_start,
    output logic                 update_ack
);

    localparam int MAG_W  = Q_BITS + 1;
    localparam int PROD_W = Q_BITS + 1 + CNT_WIDTH;
    localparam logic [MAG_W-1:0] FULL_SCALE = {1'b1, {Q_BITS{1'b0}}};

    // ---------------- stage 1: magnitude, sign, clamp ----------------
    logic [D_WIDTH-1:0] abs_val;
    logic               over;
    logic [MAG_W-1:0]   mag_c;

    // The most-negative input negates to itself; read as unsigned it still
    // has a bit at or above Q_BITS set, so it clamps like any other overflow.
    assign abs_val = pid_out[D_WIDTH-1] ? (~pid_out + D_WIDTH'(1)) : pid_out;
    assign over    = |abs_val[D_WIDTH-1:Q_BITS];
    assign mag_c   = over ? FULL_SCALE : {1'b0, abs_val[Q_BITS-1:0]};

    logic             s1_vld;
    logic [MAG_W-1:0] s1_mag;
    logic             s1_sgn;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_vld   <= 1'b0;
            s1_mag   <= '0;
            s1_sgn   <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            s1_vld <= pid_valid;
            if (pid_valid) begin
                s1_mag   <= mag_c;
                s1_sgn   <= pid_out[D_WIDTH-1];
                sat_flag <= over;
            end
        end
    end

    // ---------------- stage 2: scale to duty count ----------------
    logic [PROD_W-1:0]    prod;
    logic [PROD_W-1:0]    scaled;
    logic [CNT_WIDTH-1:0] d_c;

    assign prod   = PROD_W'(s1_mag) * PROD_W'(PERIOD);
    assign scaled = prod >> Q_BITS;
    // Slivers shorter than MIN_PULSE are dropped rather than emitted.
    assign d_c    = ((scaled != '0) && (scaled < PROD_W'(MIN_PULSE))) ? '0
                                                                      : scaled[CNT_WIDTH-1:0];

    // ---------------- period counter ----------------
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 wrap;

    assign wrap = enable && (cnt == CNT_WIDTH'(PERIOD - 1));

    always_comb begin
        cnt_nxt = '0;
        if (enable && !wrap) begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
        end
    end

    // ---------------- pending / active double buffer ----------------
    logic [CNT_WIDTH-1:0] pending;
    logic                 pending_dir;
    logic                 pending_vld;
    logic                 load;

    // While disabled there is no period to protect, so loads happen at once.
    assign load = pending_vld && (wrap || !enable);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt          <= '0;
            pending      <= '0;
            pending_dir  <= 1'b0;
            pending_vld  <= 1'b0;
            duty         <= '0;
            dir          <= 1'b0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
            update_ack   <= 1'b0;
        end else begin
            cnt <= cnt_nxt;

            // A stage-2 write coinciding with a load: the load takes the old
            // pending contents and the new value stays pending (set beats clear).
            if (s1_vld) begin
                pending     <= d_c;
                pending_dir <= s1_sgn;
                pending_vld <= 1'b1;
            end else if (load) begin
                pending_vld <= 1'b0;
            end

            if (load) begin
                duty <= pending;
                dir  <= pending_dir;
            end

            update_ack   <= load;
            pwm          <= enable && (cnt < duty);
            period_start <= enable && (cnt_nxt == '0);
        end
    end

endmodule
